// File: rtl/ss_scan_controller_pkg.sv
// Shared types and defaults for the serial scan controller.
// Imported by the top and the window matcher.
package ss_scan_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_REPORT = 2'd2
    } state_e;

    localparam int          DEF_PAT_LEN = 2;
    localparam logic [1:0]  DEF_PATTERN = 2'b11;

endpackage

// File: rtl/ss_window_match.sv
// Sliding bit window with fill tracking.
// Flags a hit when a full window equals the pattern.
module ss_window_match
    import ss_scan_controller_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic shift_en_i,
    input  logic bit_i,
    output logic hit_o
);

    localparam int FW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] win_q, win_d;
    logic [FW-1:0]      fill_q, fill_d;

    // Next window/fill; hit looks at the post-shift values.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        hit_o  = 1'b0;
        if (clear_i) begin
            win_d  = '0;
            fill_d = '0;
        end else if (shift_en_i) begin
            win_d  = {win_q[PAT_LEN-2:0], bit_i};
            fill_d = (fill_q == FW'(PAT_LEN)) ? fill_q
                                              : fill_q + FW'(1);
            hit_o  = (fill_d == FW'(PAT_LEN)) && (win_d == PATTERN);
        end
    end

    // Window and fill registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/ss_scan_controller.sv
// Word-to-serial scan sequencer with per-word hit count
// and a saturating running total.
module ss_scan_controller
    import ss_scan_controller_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 CNT_W   = 4,
    parameter int                 TOTAL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               keep_history,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   out_count,
    input  logic               clear_total,
    output logic [TOTAL_W-1:0] total_hits,
    output logic               busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SUM_W = ((TOTAL_W > CNT_W) ? TOTAL_W : CNT_W) + 1;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  sreg_q, sreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    logic               win_clear;
    logic               shift_en;
    logic               hit;
    logic               handshake;
    logic [TOTAL_W-1:0] base;
    logic [SUM_W-1:0]   sum;

    ss_window_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_match (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (win_clear),
        .shift_en_i (shift_en),
        .bit_i      (sreg_q[DATA_W-1]),
        .hit_o      (hit)
    );

    // Next state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        idx_d     = idx_q;
        hit_cnt_d = hit_cnt_q;
        win_clear = 1'b0;
        shift_en  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_count = '0;
        handshake = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sreg_d    = in_data;
                    idx_d     = '0;
                    hit_cnt_d = '0;
                    win_clear = !keep_history;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en  = 1'b1;
                sreg_d    = sreg_q << 1;
                hit_cnt_d = hit_cnt_q + CNT_W'(hit);
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DATA_W - 1))
                    state_d = S_REPORT;
            end
            S_REPORT: begin
                out_valid = 1'b1;
                out_count = hit_cnt_q;
                if (out_ready) begin
                    handshake = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Running total: clear applies before the reported count is added.
    always_comb begin
        base = clear_total ? '0 : total_q;
        sum  = SUM_W'(base) + SUM_W'(hit_cnt_q);
        if (handshake)
            total_d = (sum > SUM_W'({TOTAL_W{1'b1}})) ? '1
                                                      : sum[TOTAL_W-1:0];
        else
            total_d = base;
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Shift register, bit index, hit count and total registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg_q    <= '0;
            idx_q     <= '0;
            hit_cnt_q <= '0;
            total_q   <= '0;
        end else begin
            sreg_q    <= sreg_d;
            idx_q     <= idx_d;
            hit_cnt_q <= hit_cnt_d;
            total_q   <= total_d;
        end
    end

    assign total_hits = total_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ss_scan_controller.sv
// Directed bench for ss_scan_controller; a second instance
// with a 4-bit total exercises saturation.
module tb_ss_scan_controller;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        keep_history;
    logic        out_ready;
    logic        clear_total;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [3:0]  out_count_a;
    logic [15:0] total_a;

    logic        in_ready_b, out_valid_b, busy_b;
    logic [3:0]  out_count_b;
    logic [3:0]  total_b;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [3:0] cnt;

    ss_scan_controller #(.TOTAL_W(16)) dut_a (
        .clock        (clk),
        .reset        (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_a),
        .in_data      (in_data),
        .keep_history (keep_history),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready),
        .out_count    (out_count_a),
        .clear_total  (clear_total),
        .total_hits   (total_a),
        .busy         (busy_a)
    );

    ss_scan_controller #(.TOTAL_W(4)) dut_b (
        .clock        (clk),
        .reset        (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready_b),
        .in_data      (in_data),
        .keep_history (keep_history),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready),
        .out_count    (out_count_b),
        .clear_total  (clear_total),
        .total_hits   (total_b),
        .busy         (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Accept one word, wait for the result, then take it.
    task automatic run_word(input logic [7:0] d, input logic kh,
                            input logic clr, output logic [3:0] c);
        int n;
        in_valid     = 1'b1;
        in_data      = d;
        keep_history = kh;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 8);
        c           = out_count_a;
        clear_total = clr;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        out_ready   = 1'b0;
        clear_total = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        keep_history = 1'b0;
        out_ready    = 1'b0;
        clear_total  = 1'b0;
        #1;
        check("rst_in_ready",  in_ready_a,  1);
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_count", out_count_a, 0);
        check("rst_total",     total_a,     0);
        check("rst_busy",      busy_a,      0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic count
        run_word(8'b0110_1110, 1'b0, 1'b0, cnt);
        check("t1_count", cnt, 3);
        check("t1_total", total_a, 3);

        // 2: history across word boundary
        run_word(8'h01, 1'b1, 1'b0, cnt);
        check("t2_w1_keep", cnt, 0);
        run_word(8'h80, 1'b1, 1'b0, cnt);
        check("t2_w2_keep", cnt, 1);
        run_word(8'h01, 1'b0, 1'b0, cnt);
        check("t2_w1_clr", cnt, 0);
        run_word(8'h80, 1'b0, 1'b0, cnt);
        check("t2_w2_clr", cnt, 0);
        check("t2_total", total_a, 4);

        // 3: all ones, clear with handshake, back-to-back
        run_word(8'hFF, 1'b0, 1'b1, cnt);
        check("t3_count", cnt, 7);
        check("t3_total_clr", total_a, 7);
        run_word(8'hFF, 1'b0, 1'b0, cnt);
        check("t3_count2", cnt, 7);
        check("t3_total2", total_a, 14);

        // 4: consumer stall, producer ignored
        in_valid = 1'b1; in_data = 8'hFF; keep_history = 1'b0;
        @(posedge clk); #1;
        in_data = 8'h00;
        repeat (8) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", out_valid_a, 1);
            check("t4_count", out_count_a, 7);
            check("t4_in_ready", in_ready_a, 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t4_total", total_a, 21);
        check("t4_busy", busy_a, 0);

        // 5: reset mid-shift
        in_valid = 1'b1; in_data = 8'hFF; keep_history = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_out_valid", out_valid_a, 0);
        check("t5_out_count", out_count_a, 0);
        check("t5_total",     total_a,     0);
        check("t5_busy",      busy_a,      0);
        check("t5_in_ready",  in_ready_a,  1);
        @(posedge clk); #1;
        rst = 1'b0;
        run_word(8'h80, 1'b1, 1'b0, cnt);
        check("t5_clean_hist", cnt, 0);
        run_word(8'h03, 1'b0, 1'b0, cnt);
        check("t5_count", cnt, 1);
        check("t5_total2", total_a, 1);

        // 6: saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 3; i++) run_word(8'hFF, 1'b0, 1'b0, cnt);
        check("t6_sat", total_b, 15);
        check("t6_wide", total_a, 21);
        run_word(8'hFF, 1'b0, 1'b1, cnt);
        check("t6_clr_b", total_b, 7);
        check("t6_clr_a", total_a, 7);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
